// File: rtl/key_debounce.sv
// Purpose: synchronise and debounce active-low pushbuttons, emitting a stable level plus press/release pulses.
// Latency: a raw change first sampled at edge E reaches key_stable (and its pulse) at edge E+DEBOUNCE_CYCLES+1.
// Backpressure: none; outputs are free-running levels and single-cycle event pulses.
module key_debounce #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_stable,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  // Counter only has to reach DEBOUNCE_CYCLES-1, so ceil(log2(DEBOUNCE_CYCLES)) bits suffice.
  localparam int              CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_KEYS-1:0]            sync1;
  logic [NUM_KEYS-1:0]            sync2;
  logic [NUM_KEYS-1:0][CNT_W-1:0] cnt_q;
  logic [NUM_KEYS-1:0][CNT_W-1:0] cnt_d;
  logic [NUM_KEYS-1:0]            stable_d;
  logic [NUM_KEYS-1:0]            press_d;
  logic [NUM_KEYS-1:0]            release_d;

  // Two-flop synchroniser; resets to "released" so no spurious event follows reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  // Per-key stability counter: any agreement restarts the count, a full run of
  // disagreement accepts the new level and raises the matching event.
  always_comb begin
    cnt_d     = cnt_q;
    stable_d  = key_stable;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (sync2[i] == key_stable[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i]     = '0;
        stable_d[i]  = sync2[i];
        press_d[i]   = ~sync2[i];
        release_d[i] = sync2[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Register counters, accepted levels and event pulses together so pulses align with the level change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      key_stable  <= '1;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      cnt_q       <= cnt_d;
      key_stable  <= stable_d;
      key_press   <= press_d;
      key_release <= release_d;
    end
  end

  // A key cannot both press and release on the same edge.
  always @(posedge clk) begin
    if (reset_n) begin
      assert ((key_press & key_release) == '0);
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Purpose: randomized and directed self-checking bench for key_debounce against a window-based reference model.
// Latency: model expects level/pulse changes DEBOUNCE_CYCLES+1 edges after the first sampling edge.
// Backpressure: none; stimulus is applied on falling clock edges and outputs checked on falling edges.
module tb_key_debounce;

  localparam int NK = 4;
  localparam int D  = 8;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b1;
  logic [NK-1:0] key_raw = '1;
  logic [NK-1:0] key_stable;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;

  int n_checks = 0;
  int n_pass   = 0;

  key_debounce #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_raw     (key_raw),
    .key_stable  (key_stable),
    .key_press   (key_press),
    .key_release (key_release)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: the synchronised value seen at an edge is the raw value
  // sampled two edges earlier (1s right after reset). A key's level flips when
  // the last D synchronised samples since reset all disagree with its level.
  logic [NK-1:0] raw_hist[$];
  logic [NK-1:0] s2_hist[$];
  logic [NK-1:0] exp_stable  = '1;
  logic [NK-1:0] exp_press   = '0;
  logic [NK-1:0] exp_release = '0;
  logic [NK-1:0] m_s2, m_nxt, m_tmp;
  bit            m_all;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raw_hist.delete();
      s2_hist.delete();
      exp_stable  = '1;
      exp_press   = '0;
      exp_release = '0;
    end else begin
      m_s2 = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : '1;
      raw_hist.push_back(key_raw);
      if (raw_hist.size() > 2) void'(raw_hist.pop_front());
      s2_hist.push_back(m_s2);
      if (s2_hist.size() > D) void'(s2_hist.pop_front());
      m_nxt = exp_stable;
      if (s2_hist.size() == D) begin
        for (int k = 0; k < NK; k++) begin
          m_all = 1'b1;
          for (int j = 0; j < D; j++) begin
            m_tmp = s2_hist[j];
            if (m_tmp[k] == exp_stable[k]) m_all = 1'b0;
          end
          if (m_all) m_nxt[k] = ~exp_stable[k];
        end
      end
      exp_press   = exp_stable & ~m_nxt;
      exp_release = ~exp_stable & m_nxt;
      exp_stable  = m_nxt;
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("stable",  32'(key_stable),  32'(exp_stable));
    check("press",   32'(key_press),   32'(exp_press));
    check("release", 32'(key_release), 32'(exp_release));
  end

  // Pulse tallies for per-scenario event counts.
  int press_cnt[NK];
  int rel_cnt[NK];
  initial for (int k = 0; k < NK; k++) begin press_cnt[k] = 0; rel_cnt[k] = 0; end
  always @(negedge clk) begin
    if (reset_n) begin
      for (int k = 0; k < NK; k++) begin
        press_cnt[k] += int'(key_press[k]);
        rel_cnt[k]   += int'(key_release[k]);
      end
    end
  end

  task automatic drive(input logic [NK-1:0] v, input int cycles);
    @(negedge clk);
    key_raw = v;
    repeat (cycles) @(posedge clk);
  endtask

  // Called just after key_raw changes between edges: the next edge is the first
  // sampling edge; returns how many further edges until the masked level matches.
  task automatic wait_level(input logic [NK-1:0] mask, input logic [NK-1:0] lvl, output int n);
    bit done;
    done = 1'b0;
    n = 0;
    @(posedge clk);
    while (!done && n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if ((key_stable & mask) == (lvl & mask)) done = 1'b1;
    end
  endtask

  int n_edges;
  int pb, rb;
  logic [NK-1:0] rv;

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_stable",  32'(key_stable),  32'hF);
    check("rst_press",   32'(key_press),   32'h0);
    check("rst_release", 32'(key_release), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);

    // Clean press of key 0
    pb = press_cnt[0];
    @(negedge clk); key_raw = 4'b1110;
    wait_level(4'b0001, 4'b0000, n_edges);
    check("s1_latency", 32'(n_edges), 32'd9);
    repeat (11) @(posedge clk);
    check("s1_press_cnt", 32'(press_cnt[0] - pb), 32'd1);

    // Release of key 0
    rb = rel_cnt[0];
    @(negedge clk); key_raw = 4'b1111;
    wait_level(4'b0001, 4'b0001, n_edges);
    check("s4_latency", 32'(n_edges), 32'd9);
    repeat (5) @(posedge clk);
    check("s4_release_cnt", 32'(rel_cnt[0] - rb), 32'd1);

    // Bounce on key 1 never accepted
    pb = press_cnt[1];
    drive(4'b1101, 5); drive(4'b1111, 2); drive(4'b1101, 5); drive(4'b1111, 15);
    check("s2_stable", 32'(key_stable), 32'hF);
    check("s2_press_cnt", 32'(press_cnt[1] - pb), 32'd0);

    // Bounce on key 2 then settle low
    pb = press_cnt[2];
    drive(4'b1011, 5); drive(4'b1111, 2); drive(4'b1011, 5); drive(4'b1111, 2);
    @(negedge clk); key_raw = 4'b1011;
    wait_level(4'b0100, 4'b0000, n_edges);
    check("s3_latency", 32'(n_edges), 32'd9);
    repeat (5) @(posedge clk);
    check("s3_press_cnt", 32'(press_cnt[2] - pb), 32'd1);
    drive(4'b1111, 15);

    // All keys pressed together
    pb = press_cnt[3];
    @(negedge clk); key_raw = 4'b0000;
    wait_level(4'b1111, 4'b0000, n_edges);
    check("s5_latency", 32'(n_edges), 32'd9);
    check("s5_all_low", 32'(key_stable), 32'h0);
    repeat (3) @(posedge clk);
    check("s5_press_cnt3", 32'(press_cnt[3] - pb), 32'd1);
    drive(4'b1111, 15);

    // Reset in the middle of a count on key 3
    pb = press_cnt[3];
    drive(4'b0111, 5);
    #3 reset_n = 1'b0;
    #1;
    check("s6_rst_stable",  32'(key_stable),  32'hF);
    check("s6_rst_press",   32'(key_press),   32'h0);
    check("s6_rst_release", 32'(key_release), 32'h0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    wait_level(4'b1000, 4'b0000, n_edges);
    check("s6_latency", 32'(n_edges), 32'd9);
    repeat (5) @(posedge clk);
    check("s6_press_cnt", 32'(press_cnt[3] - pb), 32'd1);
    drive(4'b1111, 15);

    // Random held levels and glitches, checked by the model every cycle
    for (int s = 0; s < 250; s++) begin
      rv = 4'($urandom);
      drive(rv, $urandom_range(1, 20));
    end
    drive(4'b1111, 20);
    check("end_stable", 32'(key_stable), 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Front-end conditioning stage for the DE-board pushbuttons (active-low KEY[3:0]).
- Synchronises raw asynchronous button levels into clk and filters mechanical bounce with a per-key stability counter.
- key_stable drives the 4-bit in_port of the KEY parallel-input Avalon slave directly.
- Also emits one-cycle press/release event pulses for local logic, e.g. edge-capture or an interrupt source.

Parameters:
- NUM_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before accepting a new level (10 ms at 50 MHz); legal range 2..2^24.

Ports:
- clk  input  1  system clock (50 MHz nominal).
- reset_n  input  1  reset, asynchronous, active-low.
- key_raw  input  NUM_KEYS  raw pushbutton pins, active-low, asynchronous to clk.
- key_stable  output  NUM_KEYS  debounced level, active-low (1 = released); feeds the PIO in_port.
- key_press  output  NUM_KEYS  one-cycle pulse per key on accepted 1->0 transition.
- key_release  output  NUM_KEYS  one-cycle pulse per key on accepted 0->1 transition.

Behaviour:
- Reset (reset_n low, asynchronous):
  - both synchroniser stages = all 1s;
  - key_stable = all 1s (released);
  - all counters = 0;
  - key_press and key_release = 0.
  - Reset takes effect immediately regardless of clk.
- Synchroniser: two flops per key, sync1 <= key_raw and sync2 <= sync1. Only sync2 is used downstream.
- Counter: one counter per key, width ceil(log2(DEBOUNCE_CYCLES)). All keys are fully independent; no shared state.
- Per key i, each rising clk edge:
  - If sync2[i] == key_stable[i]: counter cleared to 0. Any bounce restarts the count.
  - If they differ and counter < DEBOUNCE_CYCLES-1: counter increments.
  - If they differ and counter == DEBOUNCE_CYCLES-1: key_stable[i] <= sync2[i], counter <= 0, and the matching event pulse fires on the same edge.
- Event pulses are registered:
  - key_press[i] = 1 for exactly one cycle when key_stable[i] goes 1->0;
  - key_release[i] = 1 for exactly one cycle when key_stable[i] goes 0->1;
  - otherwise both are 0.
- Latency: a raw level change first sampled at edge E appears on key_stable at edge E+DEBOUNCE_CYCLES+1, with the pulse on the same edge.
- Glitch rejection: a mismatch lasting fewer than DEBOUNCE_CYCLES consecutive sync2 cycles never changes key_stable and never pulses.
- Counter saturation: the counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Simultaneous events: any combination of keys may change or pulse on the same edge. Press and release of one key are mutually exclusive per cycle.
- Reset mid-count: partial counts are discarded and key_stable returns to 1s with no pulse. After release, a held key is re-accepted after the full latency.
- Held key: no repeated pulses while the level stays constant.

Test Plan (DEBOUNCE_CYCLES = 8, NUM_KEYS = 4):
1. Clean press: key_raw 1111 -> 1110 held 20 cycles.
   - key_stable[0] falls 9 edges after first sample.
   - key_press = 0001 for exactly 1 cycle; no other pulses.
2. Bounce rejection: key_raw[1] toggles low for 5 cycles, high 2 cycles, low 5 cycles, then high.
   - key_stable stays 1111; key_press/key_release stay 0000 throughout.
3. Bounce then settle: key_raw[2] bounces as in scenario 2, then held low.
   - key_stable[2] falls exactly 9 edges after the final 1->0 raw transition; one key_press pulse.
4. Release: after scenario 1, key_raw returns to 1111.
   - key_stable back to 1111 after 9 edges; key_release = 0001 for 1 cycle.
5. Simultaneous: key_raw 1111 -> 0000 on one edge.
   - All four key_stable bits fall on the same edge; key_press = 1111 for 1 cycle.
6. Reset mid-count: key_raw[3] low for 5 cycles, then assert reset_n low asynchronously between clock edges, release 2 cycles later with the key still held.
   - Outputs go 1111/0000/0000 immediately on reset.
   - key_stable[3] falls 9 edges after reset release; one press pulse.
